seq_pattern_gen: RTL and testbench

//  Serial test-pattern transmitter: loads a parallel bit pattern and shifts it out one bit per clock, MSB first.

---
 rtl/seq_pattern_gen_if.sv | 28 ++
 rtl/seq_pattern_gen.sv | 126 ++++++++++++
 tb/tb_seq_pattern_gen.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/seq_pattern_gen_if.sv
// rtl/seq_pattern_gen_if.sv - job request and serial output bundle for seq_pattern_gen
interface seq_pattern_gen_if #(
    parameter int WIDTH = 8,
    parameter int RW    = 4
);
    localparam int LW = $clog2(WIDTH + 1);

    logic             start;
    logic [WIDTH-1:0] pattern;
    logic [LW-1:0]    len;
    logic [RW-1:0]    reps;
    logic             dout;
    logic             dvalid;
    logic             busy;
    logic             done;

    // Controller side: issues jobs and watches the serial stream
    modport master (
        output start, pattern, len, reps,
        input  dout, dvalid, busy, done
    );

    // Generator side
    modport slave (
        input  start, pattern, len, reps,
        output dout, dvalid, busy, done
    );
endinterface

// File: rtl/seq_pattern_gen.sv
// rtl/seq_pattern_gen.sv - serial test-pattern transmitter, MSB first, with repeat passes
module seq_pattern_gen #(
    parameter int WIDTH = 8,
    parameter int RW    = 4
) (
    input  logic                 clk,
    input  logic                 clr,
    seq_pattern_gen_if.slave     bus
);
    localparam int LW = $clog2(WIDTH + 1);
    localparam logic [LW-1:0] WIDTH_LW = LW'(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    // pat_q keeps the job pattern left-aligned so bit L-1 sits at the MSB;
    // sr_q holds the bits still to go in the current pass.
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [LW-1:0]    lm1_q, lm1_d;
    logic [LW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [RW-1:0]    pass_cnt_q, pass_cnt_d;
    logic             dout_q, dout_d;
    logic             dvalid_q, dvalid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [LW-1:0]    l_eff;
    logic [WIDTH-1:0] aligned;

    // Effective length and MSB-aligned copy of the incoming pattern
    always_comb begin
        l_eff = bus.len;
        if (bus.len == '0 || bus.len > WIDTH_LW) begin
            l_eff = WIDTH_LW;
        end
        aligned = bus.pattern << (WIDTH_LW - l_eff);
    end

    // Next-state and next-output logic; outputs default to the idle value
    always_comb begin
        state_d    = state_q;
        pat_d      = pat_q;
        sr_d       = sr_q;
        lm1_d      = lm1_q;
        bit_cnt_d  = bit_cnt_q;
        pass_cnt_d = pass_cnt_q;
        dout_d     = 1'b0;
        dvalid_d   = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    pat_d      = aligned;
                    sr_d       = aligned << 1;
                    lm1_d      = l_eff - LW'(1);
                    bit_cnt_d  = l_eff - LW'(1);
                    pass_cnt_d = bus.reps;
                    dout_d     = aligned[WIDTH-1];
                    dvalid_d   = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_cnt_q != '0) begin
                    bit_cnt_d = bit_cnt_q - LW'(1);
                    dout_d    = sr_q[WIDTH-1];
                    sr_d      = sr_q << 1;
                    dvalid_d  = 1'b1;
                    busy_d    = 1'b1;
                end else if (pass_cnt_q != '0) begin
                    // Next pass follows bit 0 with no gap
                    pass_cnt_d = pass_cnt_q - RW'(1);
                    bit_cnt_d  = lm1_q;
                    dout_d     = pat_q[WIDTH-1];
                    sr_d       = pat_q << 1;
                    dvalid_d   = 1'b1;
                    busy_d     = 1'b1;
                end else begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; clr aborts everything immediately
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q    <= IDLE;
            pat_q      <= '0;
            sr_q       <= '0;
            lm1_q      <= '0;
            bit_cnt_q  <= '0;
            pass_cnt_q <= '0;
            dout_q     <= 1'b0;
            dvalid_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pat_q      <= pat_d;
            sr_q       <= sr_d;
            lm1_q      <= lm1_d;
            bit_cnt_q  <= bit_cnt_d;
            pass_cnt_q <= pass_cnt_d;
            dout_q     <= dout_d;
            dvalid_q   <= dvalid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.dout   = dout_q;
    assign bus.dvalid = dvalid_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb/tb_seq_pattern_gen.sv - self-checking bench for seq_pattern_gen
module tb_seq_pattern_gen;
    logic clk;
    logic clr;

    seq_pattern_gen_if #(.WIDTH(8), .RW(4)) bus ();

    seq_pattern_gen #(.WIDTH(8), .RW(4)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int done_cnt = 0;

    typedef struct packed {
        logic dout;
        logic dvalid;
        logic busy;
        logic done;
    } exp_t;

    exp_t exp_q[$];
    logic cap_bits[$];
    int   cap_cyc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference: a job is a list of per-cycle output tuples; idle means all zero
    always @(posedge clk or posedge clr) begin : model
        int L;
        if (clr) begin
            exp_q.delete();
        end else if (exp_q.size() > 0) begin
            void'(exp_q.pop_front());
        end else if (bus.start) begin
            L = (bus.len == 0 || bus.len > 8) ? 8 : int'(bus.len);
            for (int p = 0; p <= int'(bus.reps); p++) begin
                for (int i = L - 1; i >= 0; i--) begin
                    exp_q.push_back({bus.pattern[i], 1'b1, 1'b1, 1'b0});
                end
            end
            exp_q.push_back(4'b0001);
        end
    end

    // Per-cycle comparison against the reference, plus stream capture
    always @(negedge clk) begin : compare
        exp_t e;
        cyc++;
        if (!clr) begin
            e = (exp_q.size() > 0) ? exp_q[0] : 4'b0000;
            chk("cycle_outputs", {28'd0, bus.dout, bus.dvalid, bus.busy, bus.done}, {28'd0, e});
            if (bus.dvalid) begin
                cap_bits.push_back(bus.dout);
                cap_cyc.push_back(cyc);
            end
            if (bus.done) done_cnt++;
        end
    end

    function automatic logic [31:0] packed_cap();
        logic [31:0] v = '0;
        foreach (cap_bits[i]) v = (v << 1) | 32'(cap_bits[i]);
        return v;
    endfunction

    function automatic int count_1101();
        int n = 0;
        for (int i = 3; i < cap_bits.size(); i++) begin
            if ({cap_bits[i-3], cap_bits[i-2], cap_bits[i-1], cap_bits[i]} == 4'b1101) n++;
        end
        return n;
    endfunction

    task automatic wait_done(input int target, input string name);
        int k = 0;
        while (done_cnt < target && k < 200) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (done_cnt < target) chk({name, "_timeout"}, 32'(done_cnt), 32'(target));
        @(negedge clk);
        #1;
    endtask

    task automatic run_job(input logic [7:0] pat, input logic [3:0] l, input logic [3:0] r,
                           input string name);
        int target;
        target = done_cnt + 1;
        cap_bits.delete();
        cap_cyc.delete();
        @(negedge clk);
        bus.pattern = pat;
        bus.len     = l;
        bus.reps    = r;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start   = 1'b0;
        wait_done(target, name);
    endtask

    initial begin
        int k;
        int d0;
        clr         = 1'b1;
        bus.start   = 1'b0;
        bus.pattern = '0;
        bus.len     = '0;
        bus.reps    = '0;
        #1;
        chk("reset_outputs", {28'd0, bus.dout, bus.dvalid, bus.busy, bus.done}, 32'h0);
        repeat (2) @(negedge clk);
        clr = 1'b0;
        repeat (2) @(negedge clk);

        // 1: single pass of 1101
        run_job(8'b0000_1101, 4'd4, 4'd0, "t1");
        chk("t1_count", 32'(cap_bits.size()), 32'd4);
        chk("t1_bits", packed_cap(), 32'b1101);
        chk("t1_done_cnt", 32'(done_cnt), 32'd1);
        chk("t1_busy_after", {31'd0, bus.busy}, 32'd0);

        // 2: two passes back to back feed the 1101 detector twice
        run_job(8'b0000_1101, 4'd4, 4'd1, "t2");
        chk("t2_bits", packed_cap(), 32'b1101_1101);
        chk("t2_gapless", 32'(cap_cyc[7] - cap_cyc[0]), 32'd7);
        chk("t2_detect", 32'(count_1101()), 32'd2);

        // 3: len=0 means full width
        run_job(8'hA5, 4'd0, 4'd0, "t3");
        chk("t3_count", 32'(cap_bits.size()), 32'd8);
        chk("t3_bits", packed_cap(), 32'hA5);

        // len above WIDTH also means full width
        run_job(8'h3C, 4'd12, 4'd0, "t3b");
        chk("t3b_bits", packed_cap(), 32'h3C);

        // 4: single-bit pattern, maximum repeats
        run_job(8'h01, 4'd1, 4'd15, "t4");
        chk("t4_count", 32'(cap_bits.size()), 32'd16);
        chk("t4_bits", packed_cap(), 32'hFFFF);
        chk("t4_done_cnt", 32'(done_cnt), 32'd5);

        // 5: start held, inputs changed mid-job
        cap_bits.delete();
        cap_cyc.delete();
        d0 = done_cnt;
        @(negedge clk);
        bus.pattern = 8'h0D;
        bus.len     = 4'd4;
        bus.reps    = 4'd0;
        bus.start   = 1'b1;
        repeat (2) @(negedge clk);
        bus.pattern = 8'hF2;
        bus.reps    = 4'd3;
        bus.reps    = 4'd0;
        k = 0;
        while (cap_bits.size() < 5 && k < 50) begin
            @(negedge clk);
            #1;
            k++;
        end
        bus.start = 1'b0;
        wait_done(d0 + 2, "t5");
        chk("t5_count", 32'(cap_bits.size()), 32'd8);
        chk("t5_bits", packed_cap(), 32'b1101_0010);
        if (cap_cyc.size() >= 5) chk("t5_gap", 32'(cap_cyc[4] - cap_cyc[3]), 32'd3);
        else chk("t5_gap_missing", 32'(cap_cyc.size()), 32'd5);

        // 6: asynchronous clear during bit 3 of 8
        d0 = done_cnt;
        @(negedge clk);
        bus.pattern = 8'hA5;
        bus.len     = 4'd8;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("t6_bit3_before", {30'd0, bus.dout, bus.dvalid}, 32'b11);
        clr = 1'b1;
        #1;
        chk("t6_async_clear", {29'd0, bus.dout, bus.dvalid, bus.busy}, 32'd0);
        chk("t6_no_done", {31'd0, bus.done}, 32'd0);
        repeat (2) @(negedge clk);
        clr = 1'b0;
        repeat (12) @(negedge clk);
        #1;
        chk("t6_done_cnt", 32'(done_cnt), 32'(d0));
        chk("t6_idle", {29'd0, bus.dvalid, bus.busy, bus.done}, 32'd0);

        // fresh job after clear works normally
        run_job(8'b0000_0110, 4'd3, 4'd0, "t7");
        chk("t7_bits", packed_cap(), 32'b110);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
